// File: rtl/seg_pkg.sv
// Shared status encodings, glyph patterns and digit decoding for the 7-segment status display.
package seg_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } game_status_e;

  // Segment order is {dp,g,f,e,d,c,b,a}, active-high.
  localparam logic [7:0] GLYPH_C     = 8'h39;
  localparam logic [7:0] GLYPH_P     = 8'h73;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_D     = 8'h5E;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  function automatic logic [7:0] digit_to_seg(input logic [3:0] value);
    logic [7:0] seg;
    case (value)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = GLYPH_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] status_to_seg(input logic [1:0] status);
    logic [7:0] seg;
    case (game_status_e'(status))
      CHOSE_BOARD:  seg = GLYPH_C;
      GAMING:       seg = GLYPH_P;
      GAME_INITIAL: seg = GLYPH_DASH;
      WINNED:       seg = GLYPH_D;
      default:      seg = GLYPH_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_status_display_bin2bcd_seq.sv
// Sequential 6-bit binary to 2-digit BCD converter (shift-add-3, one bit per cycle).
module bin2bcd_seq (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd
);

  logic [2:0]  cnt_q, cnt_d;
  logic [13:0] sr_q, sr_d;
  logic        busy_q, busy_d;
  logic [13:0] adj;

  always_comb begin
    adj = sr_q;
    if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
    if (adj[9:6] >= 4'd5)   adj[9:6]   = adj[9:6] + 4'd3;
  end

  // After six shifts the BCD field is complete; done is the last busy cycle.
  assign done = busy_q && (cnt_q == 3'd6);
  assign busy = busy_q;
  assign bcd  = sr_q[13:6];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = 3'd0;
      end else begin
        sr_d  = {adj[12:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = 3'd0;
      sr_d   = {8'd0, bin};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 3'd0;
      sr_q   <= 14'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/seg_status_display.sv
// 8-digit multiplexed 7-segment status display: board number, game status glyph, step count.
module seg_status_display
  import seg_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [5:0] step_number,
  input  logic [4:0] board_num,
  input  logic [1:0] game_status,
  output logic [7:0] seg_en,
  output logic [7:0] seg_out,
  output logic       bcd_busy
);

  localparam int unsigned PreW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PreW-1:0] PreLast  = PreW'(SLOT_CYCLES - 1);
  localparam logic [PreW-1:0] PreBlank = PreW'(BLANK_CYCLES);

  logic [5:0]      board_ext;
  logic [5:0]      step_shadow_q, step_shadow_d, board_shadow_q, board_shadow_d;
  logic            step_start, board_start, step_busy, board_busy, step_done, board_done;
  logic [7:0]      step_bcd, board_bcd;
  logic [7:0]      disp_step_q, disp_step_d, disp_board_q, disp_board_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      seg_en_q, seg_en_d, seg_out_q, seg_out_d;

  assign board_ext   = {1'b0, board_num};
  assign step_start  = !step_busy && (step_number != step_shadow_q);
  assign board_start = !board_busy && (board_ext != board_shadow_q);

  bin2bcd_seq u_step_bcd (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (step_start),
    .bin     (step_number),
    .busy    (step_busy),
    .done    (step_done),
    .bcd     (step_bcd)
  );

  bin2bcd_seq u_board_bcd (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (board_start),
    .bin     (board_ext),
    .busy    (board_busy),
    .done    (board_done),
    .bcd     (board_bcd)
  );

  assign bcd_busy = step_busy | board_busy;
  assign seg_en   = seg_en_q;
  assign seg_out  = seg_out_q;

  always_comb begin
    step_shadow_d  = step_start  ? step_number : step_shadow_q;
    board_shadow_d = board_start ? board_ext   : board_shadow_q;
    disp_step_d    = step_done   ? step_bcd    : disp_step_q;
    disp_board_d   = board_done  ? board_bcd   : disp_board_q;

    pre_d = pre_q + PreW'(1);
    idx_d = idx_q;
    if (pre_q == PreLast) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end

    seg_en_d = (pre_d < PreBlank) ? 8'd0 : (8'd1 << idx_d);

    // Glyph follows the next-state display so a completed conversion shows on its done edge.
    case (idx_d)
      3'd0:    seg_out_d = digit_to_seg(disp_step_d[3:0]);
      3'd1:    seg_out_d = digit_to_seg(disp_step_d[7:4]);
      3'd4:    seg_out_d = status_to_seg(game_status);
      3'd6:    seg_out_d = digit_to_seg(disp_board_d[3:0]);
      3'd7:    seg_out_d = digit_to_seg(disp_board_d[7:4]);
      default: seg_out_d = GLYPH_BLANK;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      step_shadow_q  <= 6'd0;
      board_shadow_q <= 6'd0;
      disp_step_q    <= 8'd0;
      disp_board_q   <= 8'd0;
      pre_q          <= '0;
      idx_q          <= 3'd0;
      seg_en_q       <= 8'd0;
      seg_out_q      <= 8'd0;
    end else begin
      step_shadow_q  <= step_shadow_d;
      board_shadow_q <= board_shadow_d;
      disp_step_q    <= disp_step_d;
      disp_board_q   <= disp_board_d;
      pre_q          <= pre_d;
      idx_q          <= idx_d;
      seg_en_q       <= seg_en_d;
      seg_out_q      <= seg_out_d;
    end
  end

endmodule

// File: tb/tb_seg_status_display.sv
// Scoreboard bench: stimulus pushes expected per-slot glyphs, a negedge monitor checks each slot.
module tb_seg_status_display;

  localparam int unsigned Slot  = 20;
  localparam int unsigned Blank = 2;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] step_number = 6'd0;
  logic [4:0] board_num = 5'd0;
  logic [1:0] game_status = 2'b00;
  logic [7:0] seg_en, seg_out;
  logic       bcd_busy;

  seg_status_display #(
    .SLOT_CYCLES  (Slot),
    .BLANK_CYCLES (Blank)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .step_number (step_number),
    .board_num   (board_num),
    .game_status (game_status),
    .seg_en      (seg_en),
    .seg_out     (seg_out),
    .bcd_busy    (bcd_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         seq;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   slot_cnt = 0;
  int   blank_run = 0;
  int   busy_rises = 0;
  int   busy_cycles = 0;
  bit   saw3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] dig(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_slot(input int s, input int step, input int board,
                                          input logic [1:0] st);
    case (s)
      0: return dig(step % 10);
      1: return dig(step / 10);
      4: begin
        case (st)
          2'b00:   return 8'h39;
          2'b01:   return 8'h73;
          2'b10:   return 8'h40;
          default: return 8'h5E;
        endcase
      end
      6: return dig(board % 10);
      7: return dig(board / 10);
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: each slot start is checked for order, blanking and (if queued) its glyph.
  initial begin
    logic [7:0] prev_en;
    logic       prev_busy;
    exp_t       e;
    prev_en   = 8'd0;
    prev_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!rst) begin
        slot_cnt  = 0;
        blank_run = 0;
        prev_en   = 8'd0;
        prev_busy = 1'b0;
      end else begin
        check("seg_en_onehot0", 32'($onehot0(seg_en)), 32'd1);
        if (bcd_busy && !prev_busy) busy_rises++;
        if (bcd_busy) busy_cycles++;
        if (seg_en == 8'h01 && seg_out == 8'h4F) saw3 = 1'b1;
        if (seg_en != 8'd0 && prev_en == 8'd0) begin
          check("slot_order", 32'(seg_en), 32'(8'd1 << (slot_cnt % 8)));
          if (slot_cnt > 0) check("blank_run", 32'(blank_run), 32'(Blank));
          while (exp_q.size() > 0 && exp_q[0].seq < slot_cnt) begin
            e = exp_q.pop_front();
            check("missed_slot", 32'(e.seq), 32'(slot_cnt));
          end
          if (exp_q.size() > 0 && exp_q[0].seq == slot_cnt) begin
            e = exp_q.pop_front();
            check($sformatf("digit%0d_seg_out", slot_cnt % 8), 32'(seg_out), 32'(e.seg));
          end
          slot_cnt++;
        end
        blank_run = (seg_en == 8'd0) ? blank_run + 1 : 0;
        prev_en   = seg_en;
        prev_busy = bcd_busy;
      end
    end
  end

  task automatic push_frame();
    exp_t e;
    int   base;
    @(negedge sys_clk);
    #1;
    base = slot_cnt;
    for (int i = 0; i < 8; i++) begin
      e.seq = base + i;
      e.seg = exp_slot((base + i) % 8, int'(step_number), int'(board_num), game_status);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge sys_clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_slot0_start();
    logic [7:0] prev;
    int         n;
    n    = 0;
    prev = seg_en;
    forever begin
      @(posedge sys_clk);
      #1;
      n++;
      if ((seg_en == 8'h01 && prev == 8'h00) || n >= 400) break;
      prev = seg_en;
    end
    check("slot0_start_seen", 32'(seg_en), 32'h01);
  endtask

  initial begin
    int r0, b0;
    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      #1;
      check("rst_seg_en", 32'(seg_en), 32'd0);
      check("rst_seg_out", 32'(seg_out), 32'd0);
      check("rst_busy", 32'(bcd_busy), 32'd0);
    end
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("rel1_seg_en", 32'(seg_en), 32'd0);
    @(posedge sys_clk);
    #1;
    check("rel2_seg_en", 32'(seg_en), 32'h01);
    check("rel2_seg_out", 32'(seg_out), 32'h3F);
    push_frame();
    drain();

    // 0 -> 47 on step: exact conversion latency seen on d0.
    wait_slot0_start();
    step_number = 6'd47;
    for (int i = 1; i <= 8; i++) begin
      @(posedge sys_clk);
      #1;
      check($sformatf("busy47_c%0d", i), 32'(bcd_busy), (i <= 7) ? 32'd1 : 32'd0);
      check($sformatf("d0_47_c%0d", i), 32'(seg_out), (i < 8) ? 32'h3F : 32'h07);
    end
    repeat (4) @(posedge sys_clk);
    push_frame();
    drain();

    // 12 -> 13 -> 14 on consecutive cycles: 13 is never converted.
    #1;
    saw3 = 1'b0;
    r0 = busy_rises;
    step_number = 6'd12;
    @(posedge sys_clk);
    #1;
    step_number = 6'd13;
    @(posedge sys_clk);
    #1;
    step_number = 6'd14;
    repeat (30) @(posedge sys_clk);
    check("two_conversions", 32'(busy_rises - r0), 32'd2);
    check("no_glyph3_on_d0", 32'(saw3), 32'd0);
    push_frame();
    drain();

    // Board 31, status WINNED.
    #1;
    board_num   = 5'd31;
    game_status = 2'b11;
    repeat (10) @(posedge sys_clk);
    push_frame();
    drain();

    // Both inputs change together: conversions overlap exactly.
    #1;
    b0 = busy_cycles;
    step_number = 6'd63;
    board_num   = 5'd5;
    repeat (12) @(posedge sys_clk);
    check("parallel_busy_cycles", 32'(busy_cycles - b0), 32'd7);
    push_frame();
    drain();

    // Restart 63 -> 0.
    #1;
    step_number = 6'd0;
    game_status = 2'b10;
    repeat (10) @(posedge sys_clk);
    push_frame();
    drain();

    // Reset in the middle of a conversion, then rerun.
    #1;
    step_number = 6'd25;
    game_status = 2'b01;
    repeat (3) @(posedge sys_clk);
    #1;
    check("busy_before_rst", 32'(bcd_busy), 32'd1);
    rst = 1'b0;
    @(posedge sys_clk);
    #1;
    check("midrst_busy", 32'(bcd_busy), 32'd0);
    check("midrst_seg_en", 32'(seg_en), 32'd0);
    check("midrst_seg_out", 32'(seg_out), 32'd0);
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("rerun_busy", 32'(bcd_busy), 32'd1);
    repeat (10) @(posedge sys_clk);
    push_frame();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
